interrupt_ctrl: RTL

INTERRUPT_CTRL -- requirements
Module: interrupt_ctrl

---
 rtl/interrupt_ctrl_pkg.sv | 25 ++
 rtl/interrupt_ctrl_irq_arbiter.sv | 24 ++
 rtl/interrupt_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/interrupt_ctrl_pkg.sv
// Shared types and trap-cause constants for the machine-mode interrupt controller.
// The WFI state exists only when INTERRUPT_CTRL_WFI_EN is defined.
package interrupt_ctrl_pkg;

`ifdef INTERRUPT_CTRL_WFI_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TAKE,
    ST_ISR,
    ST_RET,
    ST_WFI
  } ictrl_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TAKE,
    ST_ISR,
    ST_RET
  } ictrl_state_e;
`endif

  localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;
  localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;

endpackage

// File: rtl/interrupt_ctrl_irq_arbiter.sv
// Combinational priority selection between the external and timer interrupt sources.
// The external interrupt wins when both are enabled and pending.
module irq_arbiter
  import interrupt_ctrl_pkg::*;
(
  input  logic        i_mie,
  input  logic        i_meie,
  input  logic        i_mtie,
  input  logic        i_meip,
  input  logic        i_mtip,
  output logic        o_pending,
  output logic [31:0] o_cause
);

  logic w_ext;
  logic w_tmr;

  assign w_ext     = i_mie & i_meie & i_meip;
  assign w_tmr     = i_mie & i_mtie & i_mtip;
  assign o_pending = w_ext | w_tmr;
  // Cause is only consumed while o_pending is high.
  assign o_cause   = w_ext ? CAUSE_MEI : CAUSE_MTI;

endmodule

// File: rtl/interrupt_ctrl.sv
// Machine-mode interrupt entry/return sequencer; advances only when both pipeline sides are idle.
// Define INTERRUPT_CTRL_WFI_EN to add the WFI sleep state and the pipeline stall.
module interrupt_ctrl
  import interrupt_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        IF_DONE,
  input  logic        MEM_DONE,
  input  logic        MIE,
  input  logic        MEIE,
  input  logic        MTIE,
  input  logic        MEIP,
  input  logic        MTIP,
  input  logic [31:0] MTVEC,
  input  logic [31:0] MEPC,
  input  logic        EX_valid,
  input  logic [31:0] EX_pc,
  input  logic        EX_mret,
  input  logic        EX_wfi,
  output logic        interrupt_taken,
  output logic        interrupt_return,
  output logic [31:0] EX_mepc,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        stall,
  output logic [31:0] mcause,
  output logic        in_isr
);

  ictrl_state_e r_state;
  ictrl_state_e w_state_nxt;
  logic [31:0]  r_epc;
  logic [31:0]  r_mcause;
  logic [31:0]  w_epc_nxt;
  logic [31:0]  w_mcause_nxt;
  logic         w_step;
  logic         w_pending;
  logic [31:0]  w_cause;

  assign w_step = IF_DONE & MEM_DONE;

  irq_arbiter u_arb (
    .i_mie     (MIE),
    .i_meie    (MEIE),
    .i_mtie    (MTIE),
    .i_meip    (MEIP),
    .i_mtip    (MTIP),
    .o_pending (w_pending),
    .o_cause   (w_cause)
  );

  // NOTE: every state-holding assignment is non-blocking so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_epc    <= '0;
      r_mcause <= '0;
    end else if (w_step) begin
      r_state  <= w_state_nxt;
      r_epc    <= w_epc_nxt;
      r_mcause <= w_mcause_nxt;
    end
  end

  // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
  always_comb begin
    w_state_nxt  = r_state;
    w_epc_nxt    = r_epc;
    w_mcause_nxt = r_mcause;
    case (r_state)
      ST_IDLE: begin
        if (w_pending && EX_valid) begin
          w_state_nxt  = ST_TAKE;
          w_epc_nxt    = EX_pc;
          w_mcause_nxt = w_cause;
        end else if (EX_valid && EX_mret) begin
          w_state_nxt = ST_RET;
`ifdef INTERRUPT_CTRL_WFI_EN
        end else if (EX_valid && EX_wfi) begin
          w_state_nxt = ST_WFI;
`endif
        end
      end
      ST_TAKE: w_state_nxt = ST_ISR;
      // Pending interrupts are ignored here: no nesting.
      ST_ISR: begin
        if (EX_valid && EX_mret) w_state_nxt = ST_RET;
      end
      ST_RET:  w_state_nxt = ST_IDLE;
`ifdef INTERRUPT_CTRL_WFI_EN
      // Wake resumes after the wfi, so the saved PC skips it.
      ST_WFI: begin
        if (w_pending) begin
          w_state_nxt  = ST_TAKE;
          w_epc_nxt    = EX_pc + 32'd4;
          w_mcause_nxt = w_cause;
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign interrupt_taken  = (r_state == ST_TAKE);
  assign interrupt_return = (r_state == ST_RET);
  assign flush            = interrupt_taken | interrupt_return;
  assign redirect         = flush;
  assign redirect_pc      = interrupt_taken  ? MTVEC :
                            interrupt_return ? MEPC  : 32'd0;
  assign EX_mepc          = r_epc;
  assign mcause           = r_mcause;
  assign in_isr           = (r_state == ST_ISR);

`ifdef INTERRUPT_CTRL_WFI_EN
  assign stall = (r_state == ST_WFI);
`else
  logic w_unused_wfi;
  assign w_unused_wfi = EX_wfi;
  assign stall        = 1'b0;
`endif

endmodule
